// File: rtl/score_bcd_counter_pkg.sv
// Shared types for the BCD score counter: digit type, FSM states, constants.
// DEC state exists only when SCORE_MISS_PENALTY_EN is defined.
package score_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_NINE = 4'd9;
  localparam bcd_t BCD_ZERO = 4'd0;

`ifdef SCORE_MISS_PENALTY_EN
  typedef enum logic [1:0] {
    IDLE,
    INC,
    DEC
  } state_t;
`else
  typedef enum logic {
    IDLE,
    INC
  } state_t;
`endif

endpackage

// File: rtl/score_bcd_counter_if.sv
// Game-side bundle: hit/miss/clear/frame_start in; digits/busy/saturated out.
// master = game logic / bench, slave = score_bcd_counter.
interface score_bcd_counter_if #(
  parameter int DIGITS = 3
);

  logic                hit;
  logic                miss;
  logic                clear;
  logic                frame_start;
  logic [4*DIGITS-1:0] digits;
  logic                busy;
  logic                saturated;

  modport master (
    output hit, miss, clear, frame_start,
    input  digits, busy, saturated
  );

  modport slave (
    input  hit, miss, clear, frame_start,
    output digits, busy, saturated
  );

endinterface

// File: rtl/bcd_digit_step.sv
// One BCD digit +1/-1 step with carry/borrow out.
// Ports: i_digit, i_dec (1=decrement) -> o_digit, o_cout.
module bcd_digit_step
  import score_pkg::*;
(
  input  bcd_t i_digit,
  input  logic i_dec,
  output bcd_t o_digit,
  output logic o_cout
);

  logic w_nine;
  logic w_zero;

  assign w_nine = (i_digit == BCD_NINE);
  assign w_zero = (i_digit == BCD_ZERO);

  always_comb begin
    o_digit = i_digit;
    o_cout  = 1'b0;
    unique case (1'b1)
      (i_dec && w_zero): begin
        o_digit = BCD_NINE;
        o_cout  = 1'b1;
      end
      (i_dec && !w_zero): o_digit = i_digit - 4'd1;
      (!i_dec && w_nine): begin
        o_digit = BCD_ZERO;
        o_cout  = 1'b1;
      end
      default: o_digit = i_digit + 4'd1;
    endcase
  end

endmodule

// File: rtl/score_bcd_counter.sv
// Hit/miss pulse accumulator into a DIGITS-wide BCD score, one digit/clock,
// with a tear-free frame-latched display. Ports: clk, rst_n, ifc (slave).
// Optional miss penalty: define SCORE_MISS_PENALTY_EN.
module score_bcd_counter
  import score_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int PEND_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_bcd_counter_if.slave   ifc
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(DIGITS - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  state_t              r_state;
  state_t              w_state_nx;
  logic [IDX_W-1:0]    r_idx;
  logic [IDX_W-1:0]    w_idx_nx;
  bcd_t                r_score [DIGITS];
  logic [PEND_W-1:0]   r_pend;
  logic                r_sat;
  logic                r_latch_req;
  logic [4*DIGITS-1:0] r_digits;

  logic                w_all9;
  logic                w_idle;
  bcd_t                w_cur;
  bcd_t                w_nxt_dig;
  logic                w_cout;
  logic                w_dec;
  logic                w_wr_en;
  logic                w_cons_hit;
  logic                w_sat_set;
  logic [4*DIGITS-1:0] w_score_flat;

`ifdef SCORE_MISS_PENALTY_EN
  logic [PEND_W-1:0]   r_pend_miss;
  logic                w_cons_miss;
  logic                w_all0;
`else
  logic                w_unused_miss;
  assign w_unused_miss = ifc.miss;
`endif

  always_comb begin
    w_all9       = 1'b1;
    w_cur        = BCD_ZERO;
    w_score_flat = '0;
    for (int i = 0; i < DIGITS; i++) begin
      w_all9 = w_all9 & (r_score[i] == BCD_NINE);
      w_score_flat[4*i +: 4] = r_score[i];
      if (r_idx == IDX_W'(i)) w_cur = r_score[i];
    end
  end

`ifdef SCORE_MISS_PENALTY_EN
  always_comb begin
    w_all0 = 1'b1;
    for (int i = 0; i < DIGITS; i++)
      w_all0 = w_all0 & (r_score[i] == BCD_ZERO);
  end
  assign w_dec = (r_state == DEC);
`else
  assign w_dec = 1'b0;
`endif

  assign w_idle = (r_state == IDLE);

  bcd_digit_step u_step (
    .i_digit (w_cur),
    .i_dec   (w_dec),
    .o_digit (w_nxt_dig),
    .o_cout  (w_cout)
  );

  always_comb begin
    w_state_nx = r_state;
    w_idx_nx   = r_idx;
    w_wr_en    = 1'b0;
    w_cons_hit = 1'b0;
    w_sat_set  = 1'b0;
`ifdef SCORE_MISS_PENALTY_EN
    w_cons_miss = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (r_pend != '0) begin
          w_cons_hit = 1'b1;
          if (w_all9) begin
            w_sat_set = 1'b1;
          end else begin
            w_idx_nx   = '0;
            w_state_nx = INC;
          end
        end
`ifdef SCORE_MISS_PENALTY_EN
        else if (r_pend_miss != '0) begin
          w_cons_miss = 1'b1;
          if (!w_all0) begin
            w_idx_nx   = '0;
            w_state_nx = DEC;
          end
        end
`endif
      end
      default: begin
        // carry/borrow ripples one digit per clock
        w_wr_en = 1'b1;
        if (w_cout && r_idx != LAST) begin
          w_idx_nx = r_idx + 1'b1;
        end else begin
          w_state_nx = IDLE;
        end
      end
    endcase
    if (ifc.clear) begin
      w_state_nx = IDLE;
      w_idx_nx   = '0;
      w_wr_en    = 1'b0;
      w_cons_hit = 1'b0;
      w_sat_set  = 1'b0;
`ifdef SCORE_MISS_PENALTY_EN
      w_cons_miss = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_idx       <= '0;
      r_pend      <= '0;
      r_sat       <= 1'b0;
      r_latch_req <= 1'b0;
      r_digits    <= '0;
      for (int i = 0; i < DIGITS; i++) r_score[i] <= BCD_ZERO;
    end else begin
      r_state <= w_state_nx;
      r_idx   <= w_idx_nx;

      if (ifc.clear) begin
        r_pend <= '0;
      end else if (ifc.hit && !w_cons_hit) begin
        if (r_pend != PEND_MAX) r_pend <= r_pend + 1'b1;
      end else if (!ifc.hit && w_cons_hit) begin
        r_pend <= r_pend - 1'b1;
      end

      if (ifc.clear)      r_sat <= 1'b0;
      else if (w_sat_set) r_sat <= 1'b1;

      for (int i = 0; i < DIGITS; i++) begin
        if (ifc.clear)
          r_score[i] <= BCD_ZERO;
        else if (w_wr_en && r_idx == IDX_W'(i))
          r_score[i] <= w_nxt_dig;
      end

      // only IDLE cycles see a fully settled score
      if (ifc.frame_start && w_idle) begin
        r_digits    <= w_score_flat;
        r_latch_req <= 1'b0;
      end else if (ifc.frame_start) begin
        r_latch_req <= 1'b1;
      end else if (r_latch_req && w_idle) begin
        r_digits    <= w_score_flat;
        r_latch_req <= 1'b0;
      end
    end
  end

`ifdef SCORE_MISS_PENALTY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend_miss <= '0;
    end else if (ifc.clear) begin
      r_pend_miss <= '0;
    end else if (ifc.miss && !w_cons_miss) begin
      if (r_pend_miss != PEND_MAX) r_pend_miss <= r_pend_miss + 1'b1;
    end else if (!ifc.miss && w_cons_miss) begin
      r_pend_miss <= r_pend_miss - 1'b1;
    end
  end

  assign ifc.busy = !w_idle || (r_pend != '0) || (r_pend_miss != '0);
`else
  assign ifc.busy = !w_idle || (r_pend != '0);
`endif

  assign ifc.digits    = r_digits;
  assign ifc.saturated = r_sat;

endmodule

// File: tb/tb_score_bcd_counter.sv
// Scoreboard bench for score_bcd_counter: integer reference model,
// queued expectations, negedge monitor. Honours SCORE_MISS_PENALTY_EN.
module tb_score_bcd_counter;

  localparam int DIGITS = 3;
  localparam int PMAX   = 15;
  localparam int MAXS   = 10**DIGITS - 1;
`ifdef SCORE_MISS_PENALTY_EN
  localparam bit MISS_EN = 1'b1;
`else
  localparam bit MISS_EN = 1'b0;
`endif

  logic clk;
  logic rst_n;

  score_bcd_counter_if #(.DIGITS(DIGITS)) ifc ();

  score_bcd_counter #(
    .DIGITS (DIGITS),
    .PEND_W (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ifc   (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4*DIGITS-1:0] d;
    logic                b;
    logic                s;
    string               nm;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   n_chk;
  int   n_fail;

  int m_score, m_pend, m_pmiss, m_cnt, m_disp;
  bit m_sat, m_req, m_dec;

  function automatic logic [4*DIGITS-1:0] to_bcd(input int v);
    logic [4*DIGITS-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  function automatic int trail(input int v, input int dig);
    int n;
    int t;
    n = 0;
    t = v;
    while (n < DIGITS && (t % 10) == dig) begin
      n++;
      t = t / 10;
    end
    return n;
  endfunction

  function automatic int clamp(input int v);
    return (v > PMAX) ? PMAX : v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_score = 0; m_pend = 0; m_pmiss = 0; m_cnt = 0;
      m_disp = 0; m_sat = 0; m_req = 0; m_dec = 0;
    end else begin
      bit idle;
      bit ch;
      bit cm;
      int h;
      int mi;
      int sc0;
      idle = (m_cnt == 0);
      sc0  = m_score;
      h    = int'(ifc.hit);
      mi   = int'(ifc.miss);
      ch   = idle && m_pend != 0 && !ifc.clear;
      cm   = MISS_EN && idle && m_pend == 0 && m_pmiss != 0 && !ifc.clear;
      if (ifc.frame_start && idle) begin
        m_disp = sc0; m_req = 0;
      end else if (ifc.frame_start) begin
        m_req = 1;
      end else if (m_req && idle) begin
        m_disp = sc0; m_req = 0;
      end
      if (ifc.clear) begin
        m_score = 0; m_pend = 0; m_pmiss = 0; m_sat = 0; m_cnt = 0;
      end else begin
        if (m_cnt > 0) begin
          m_cnt--;
          if (m_cnt == 0) m_score = m_dec ? m_score - 1 : m_score + 1;
        end else if (ch) begin
          if (m_score == MAXS) m_sat = 1;
          else begin m_cnt = trail(m_score, 9) + 1; m_dec = 0; end
        end else if (cm) begin
          if (m_score != 0) begin m_cnt = trail(m_score, 0) + 1; m_dec = 1; end
        end
        m_pend  = clamp(m_pend + h - int'(ch));
        m_pmiss = MISS_EN ? clamp(m_pmiss + mi - int'(cm)) : 0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      while (q.size() != 0) begin
        mon_e = q.pop_front();
        n_chk += 3;
        if (ifc.digits !== mon_e.d) begin
          n_fail++;
          $display("FAIL %s digits: got %h expected %h", mon_e.nm, ifc.digits, mon_e.d);
        end
        if (ifc.busy !== mon_e.b) begin
          n_fail++;
          $display("FAIL %s busy: got %b expected %b", mon_e.nm, ifc.busy, mon_e.b);
        end
        if (ifc.saturated !== mon_e.s) begin
          n_fail++;
          $display("FAIL %s saturated: got %b expected %b", mon_e.nm, ifc.saturated, mon_e.s);
        end
      end
    end
  end

  task automatic expect_now(input string nm);
    exp_t e;
    e.d  = to_bcd(m_disp);
    e.b  = (m_cnt != 0) || (m_pend != 0) || (m_pmiss != 0);
    e.s  = m_sat;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic step(input bit h, input bit m, input bit c, input bit f);
    ifc.hit = h; ifc.miss = m; ifc.clear = c; ifc.frame_start = f;
    @(posedge clk); #1;
    ifc.hit = 0; ifc.miss = 0; ifc.clear = 0; ifc.frame_start = 0;
  endtask

  task automatic wait_idle(input int limit);
    int n;
    n = 0;
    while (ifc.busy === 1'b1 && n < limit) begin
      step(0, 0, 0, 0);
      n++;
    end
    n_chk++;
    if (ifc.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL wait_idle: busy still %b after %0d cycles", ifc.busy, n);
    end
  endtask

  task automatic latch_check(input string nm);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    expect_now(nm);
  endtask

  task automatic add_points(input int n);
    int left;
    int k;
    left = n;
    while (left > 0) begin
      k = (left > 14) ? 14 : left;
      repeat (k) step(1, 0, 0, 0);
      left -= k;
      wait_idle(300);
    end
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    ifc.hit = 0; ifc.miss = 0; ifc.clear = 0; ifc.frame_start = 0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1;
    expect_now("reset");
    rst_n = 1;
    step(0, 0, 0, 0);

    repeat (5) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    wait_idle(100);
    expect_now("five_pre_latch");
    latch_check("five_hits");

    step(0, 0, 1, 0);
    add_points(99);
    latch_check("score_099");
    step(1, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 0, i == 1);
      expect_now("carry_no_tear");
    end
    latch_check("score_100");

    step(0, 0, 1, 0);
    add_points(99);
    latch_check("score_099_b");
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    rst_n = 0;
    #1;
    expect_now("rst_mid_inc");
    @(posedge clk); #1;
    rst_n = 1;
    step(0, 0, 0, 0);

    repeat (20) step(1, 0, 0, 0);
    expect_now("burst_busy");
    wait_idle(400);
    latch_check("burst20");

    step(0, 0, 1, 0);
    add_points(MAXS);
    latch_check("score_999");
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    wait_idle(50);
    latch_check("sat_999");
    step(0, 0, 1, 0);
    latch_check("cleared");

`ifdef SCORE_MISS_PENALTY_EN
    step(0, 0, 1, 0);
    add_points(10);
    step(0, 1, 0, 0);
    wait_idle(50);
    latch_check("miss_010");
    step(0, 0, 1, 0);
    step(0, 1, 0, 0);
    wait_idle(50);
    latch_check("miss_floor");
    add_points(5);
    step(1, 1, 0, 0);
    wait_idle(50);
    latch_check("hit_miss_same");
`endif

    for (int i = 0; i < 400; i++) begin
      step($urandom_range(2) == 0, $urandom_range(3) == 0,
           $urandom_range(60) == 0, $urandom_range(5) == 0);
      if (i % 5 == 4) expect_now("random");
    end
    wait_idle(400);
    latch_check("final");

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
